// File: rtl/rv32_pmp_checker.sv
// Sequential PMP checker: scans the decoded regions one per clock in priority
// order and returns allow/deny plus the matching region over valid/ready.
module rv32_pmp_checker #(
  parameter int NB_REGION  = 16,
  parameter int RLEN       = 34,
  parameter int XLEN       = 32,
  parameter int AXI_ADDR_W = XLEN
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [AXI_ADDR_W-1:0]     req_addr,
  input  logic [2:0]                req_type,
  input  logic                      req_mmode,
  input  logic [8*NB_REGION-1:0]    pmp_cfg,
  input  logic [XLEN*NB_REGION-1:0] pmp_addr,
  input  logic [RLEN*NB_REGION-1:0] pmp_base,
  input  logic [RLEN*NB_REGION-1:0] pmp_mask,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic                      rsp_allow,
  output logic                      rsp_match,
  output logic [3:0]                rsp_region
);

  // state | meaning
  // IDLE  | ready for a new request
  // SCAN  | evaluating region idx_q this cycle
  // RESP  | result held until rsp_ready
  typedef enum logic [1:0] {IDLE, SCAN, RESP} state_t;

  localparam int IDX_W = (NB_REGION > 1) ? $clog2(NB_REGION) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NB_REGION - 1);

  state_t           state_q;
  logic [IDX_W-1:0] idx_q;
  logic [RLEN-1:0]  addr_q;
  logic [2:0]       type_q;
  logic             mmode_q;
  logic             req_ready_q;
  logic             rsp_valid_q;
  logic             rsp_allow_q;
  logic             rsp_match_q;
  logic [3:0]       rsp_region_q;

  logic [7:0]       cfg_sel;
  logic [RLEN-1:0]  base_sel;
  logic [RLEN-1:0]  mask_sel;
  logic [RLEN-1:0]  tor_hi;
  logic [RLEN-1:0]  tor_lo;
  logic             hit;
  logic             type_ok;
  logic             allow_hit;
  int unsigned      idx_i;

  always_comb begin
    idx_i    = 32'(idx_q);
    cfg_sel  = pmp_cfg[idx_i*8 +: 8];
    base_sel = pmp_base[idx_i*RLEN +: RLEN];
    mask_sel = pmp_mask[idx_i*RLEN +: RLEN];
    tor_hi   = RLEN'({pmp_addr[idx_i*XLEN +: XLEN], 2'b00});
    tor_lo   = '0;
    if (idx_i != 0) tor_lo = RLEN'({pmp_addr[(idx_i-1)*XLEN +: XLEN], 2'b00});
    case (cfg_sel[4:3])
      2'b00:   hit = 1'b0;
      2'b01:   hit = (tor_lo < tor_hi) && (addr_q >= tor_lo) && (addr_q < tor_hi);
      default: hit = ((addr_q & mask_sel) == base_sel);
    endcase
    type_ok   = $onehot(type_q);
    // Unlocked regions do not constrain machine mode.
    allow_hit = type_ok && ((mmode_q && !cfg_sel[7]) || ((type_q & ~cfg_sel[2:0]) == 3'b000));
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      addr_q       <= '0;
      type_q       <= '0;
      mmode_q      <= 1'b0;
      req_ready_q  <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_allow_q  <= 1'b0;
      rsp_match_q  <= 1'b0;
      rsp_region_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          req_ready_q <= 1'b1;
          if (req_valid && req_ready_q) begin
            addr_q      <= RLEN'(req_addr);
            type_q      <= req_type;
            mmode_q     <= req_mmode;
            idx_q       <= '0;
            req_ready_q <= 1'b0;
            state_q     <= SCAN;
          end
        end
        SCAN: begin
          if (hit || idx_q == LAST_IDX) begin
            rsp_valid_q  <= 1'b1;
            rsp_allow_q  <= hit ? allow_hit : (mmode_q && type_ok);
            rsp_match_q  <= hit;
            rsp_region_q <= hit ? 4'(idx_q) : 4'd0;
            state_q      <= RESP;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready  = req_ready_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_allow  = rsp_allow_q;
  assign rsp_match  = rsp_match_q;
  assign rsp_region = rsp_region_q;

endmodule
